// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : Program-counter stage: next-PC select, PC register, stall/halt
//            control, misaligned JR trapping and retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [15:0] imm,
    input  logic [25:0] jump_addr,
    input  logic [31:0] rs_data,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] instr_count
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic        halted_q;
    logic        err_q;

    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    assign PC_plus4      = pc_q + 32'd4;
    assign branch_offset = {{14{imm[15]}}, imm, 2'b00};
    assign branch_target = PC_plus4 + branch_offset;
    assign jump_target   = {PC_plus4[31:28], jump_addr, 2'b00};
    assign jr_misaligned = jump_reg && (rs_data[1:0] != 2'b00);

    // Only the JR target can be misaligned; it diverts to the trap vector.
    always_comb begin
        next_pc = PC_plus4;
        if (jump_reg) begin
            next_pc = jr_misaligned ? TRAP_VECTOR : rs_data;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (PCSrc) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc_q     <= RESET_VECTOR;
            count_q  <= 32'd0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else if (!stall) begin
                        pc_q    <= next_pc;
                        count_q <= count_q + 32'd1;
                        if (jr_misaligned) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state    <= HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign PC           = pc_q;
    assign halted       = halted_q;
    assign misalign_err = err_q;
    assign instr_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed self-checking bench for pc_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic        jump;
    logic        jump_reg;
    logic [15:0] imm;
    logic [25:0] jump_addr;
    logic [31:0] rs_data;
    logic        stall;
    logic        halt;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        halted;
    logic        misalign_err;
    logic [31:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrc        (PCSrc),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .imm          (imm),
        .jump_addr    (jump_addr),
        .rs_data      (rs_data),
        .stall        (stall),
        .halt         (halt),
        .PC           (PC),
        .PC_plus4     (PC_plus4),
        .halted       (halted),
        .misalign_err (misalign_err),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCSrc = 0; jump = 0; jump_reg = 0; imm = '0; jump_addr = '0;
        rs_data = '0; stall = 0; halt = 0;
    endtask

    task automatic jr_to(input logic [31:0] target);
        idle_inputs();
        jump_reg = 1; rs_data = target;
        step();
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #12;
        check("reset_pc", PC, 32'h0);
        check("reset_pc_plus4", PC_plus4, 32'h4);
        check("reset_count", instr_count, 32'h0);
        check("reset_halted", {31'b0, halted}, 32'h0);
        check("reset_err", {31'b0, misalign_err}, 32'h0);

        // Release away from the edge; first increment on the next edge.
        @(negedge clk);
        rst = 0;
        step(); check("seq_pc1", PC, 32'h4);
        step(); check("seq_pc2", PC, 32'h8);
        step(); check("seq_pc3", PC, 32'hC);
        check("seq_count", instr_count, 32'd3);

        // Asynchronous reset mid-cycle.
        #2 rst = 1;
        #1;
        check("async_rst_pc", PC, 32'h0);
        check("async_rst_count", instr_count, 32'h0);
        @(negedge clk);
        rst = 0;
        check("rst_release_pc", PC, 32'h0);

        // Branch arithmetic.
        jr_to(32'h100);
        check("jr_0x100", PC, 32'h100);
        PCSrc = 1; imm = 16'hFFFE; step(); idle_inputs();
        check("branch_neg", PC, 32'hFC);
        jr_to(32'h100);
        PCSrc = 1; imm = 16'h0003; step(); idle_inputs();
        check("branch_pos", PC, 32'h110);
        jr_to(32'hFFFF_FFFC);
        check("wrap_pc_plus4", PC_plus4, 32'h0);
        step();
        check("wrap_pc", PC, 32'h0);
        check("count_6", instr_count, 32'd6);

        // Priority.
        jr_to(32'h1000_0000);
        jump = 1; PCSrc = 1; imm = 16'h0010; jump_addr = 26'h10; step(); idle_inputs();
        check("jump_over_branch", PC, 32'h1000_0040);
        jump_reg = 1; rs_data = 32'h2000; jump = 1; PCSrc = 1; jump_addr = 26'h10; imm = 16'h0010;
        step(); idle_inputs();
        check("jr_over_jump", PC, 32'h2000);
        check("err_clear", {31'b0, misalign_err}, 32'h0);
        check("count_9", instr_count, 32'd9);

        // Misaligned JR traps.
        jr_to(32'h2002);
        check("trap_pc", PC, 32'h80);
        check("trap_err", {31'b0, misalign_err}, 32'h1);
        check("trap_count", instr_count, 32'd10);
        repeat (5) step();
        check("err_sticky", {31'b0, misalign_err}, 32'h1);
        check("post_trap_pc", PC, 32'h94);
        check("count_15", instr_count, 32'd15);

        // Stall drops the branch.
        stall = 1; PCSrc = 1; imm = 16'h0005;
        repeat (2) step();
        idle_inputs();
        check("stall_pc", PC, 32'h94);
        check("stall_count", instr_count, 32'd15);

        // Halt overrides stall; frozen afterwards.
        halt = 1; stall = 1; step(); idle_inputs();
        check("halted_set", {31'b0, halted}, 32'h1);
        check("halt_pc", PC, 32'h94);
        jump = 1; jump_addr = 26'h3FF; jump_reg = 1; rs_data = 32'h3;
        repeat (10) step();
        idle_inputs();
        check("halted_pc", PC, 32'h94);
        check("halted_count", instr_count, 32'd15);
        check("halted_hold", {31'b0, halted}, 32'h1);
        check("halted_err", {31'b0, misalign_err}, 32'h1);
        step();
        check("halted_stays", {31'b0, halted}, 32'h1);

        // Only reset leaves HALTED.
        #2 rst = 1;
        #1;
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_err", {31'b0, misalign_err}, 32'h0);
        @(negedge clk);
        rst = 0;
        step();
        check("run_after_rst", PC, 32'h4);

        // Counter wrap.
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        check("count_preload", instr_count, 32'hFFFF_FFFF);
        step();
        check("count_wrap", instr_count, 32'h0);
        check("wrap_step_pc", PC, 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Program-counter stage for the single-cycle MIPS core. It sits directly downstream of the branch-control logic and consumes its `PCSrc` decision together with jump controls from the main decoder. It computes next-PC (sequential, branch, jump, jump-register) and holds the PC register. It also provides stall and halt control, misaligned-target trapping, and a retired-instruction counter.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset
- `TRAP_VECTOR`, 32'h0000_0080, PC value loaded when a selected target is misaligned
- `clk`  input  1  sole clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `PCSrc`  input  1  take conditional branch (from branch control)
- `jump`  input  1  J/JAL: take pseudo-direct jump
- `jump_reg`  input  1  JR: jump to `rs_data`
- `imm`  input  16  raw branch offset field (instr[15:0]), word offset
- `jump_addr`  input  26  jump field (instr[25:0])
- `rs_data`  input  32  register value for JR
- `stall`  input  1  hold PC this cycle
- `halt`  input  1  enter HALTED state (e.g. decoded halt/syscall)
- `PC`  output  32  current instruction address (registered)
- `PC_plus4`  output  32  PC + 4, combinational (for JAL link and branch base)
- `halted`  output  1  high while in HALTED state
- `misalign_err`  output  1  sticky: a misaligned target was trapped
- `instr_count`  output  32  retired-instruction counter

## Operation
- State machine, two states: RUN, HALTED. Reset → RUN.
- RUN and `halt`=1 → HALTED. PC is not updated that cycle, and the counter does not increment. `halt` overrides `stall` and all redirects.
- HALTED: PC, counter and `misalign_err` are frozen, and all inputs are ignored. Only `rst` exits.
- RUN and `halt`=0 and `stall`=1: PC and counter hold.
- RUN and `halt`=0 and `stall`=0: PC loads next-PC and `instr_count` increments by 1.
- Next-PC priority (highest first): `jump_reg` → `rs_data`; `jump` → {PC_plus4[31:28], jump_addr, 2'b00}; `PCSrc` → branch target; else `PC_plus4`.
- Branch target = PC_plus4 + {{14{imm[15]}}, imm, 2'b00}, computed modulo 2^32 with no overflow detection.
- `PC_plus4` = PC + 4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Misalignment check applies only to the `jump_reg` target; other targets are aligned by construction.
  - If `rs_data`[1:0] ≠ 0 on a JR advance, PC loads `TRAP_VECTOR` and `misalign_err` sets to 1.
  - `misalign_err` stays set until `rst`. The counter still increments.
- `instr_count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values, applied asynchronously while `rst`=1: PC=`RESET_VECTOR`, state=RUN, `halted`=0, `misalign_err`=0, `instr_count`=0. `PC_plus4` follows as `RESET_VECTOR`+4.
- Latency: a redirect presented in cycle N appears on `PC` after the rising edge ending cycle N, i.e. one-cycle latency.
- `PC` and `halted` are registered; `PC_plus4` is combinational from `PC`.
- `halted` rises on the edge that samples `halt`=1 in RUN.
- Simultaneous `stall`=1 and `PCSrc`=1: the redirect is dropped. Upstream must re-present it after the stall.
- `rst` asserted mid-operation, including in HALTED, takes effect immediately without waiting for an edge. Release is synchronous to the next edge; the first increment occurs on the first edge with `rst`=0.

## Test plan
- Sequential and reset: release `rst` and run 3 cycles with no controls. PC goes 0x0 → 0x4 → 0x8 → 0xC and `instr_count`=3. Assert `rst` asynchronously mid-cycle: PC=0x0 and `instr_count`=0 immediately.
- Branch arithmetic:
  - PC=0x100, `PCSrc`=1, imm=16'hFFFE: next PC=0xFC.
  - PC=0x100, imm=16'h0003: next PC=0x110.
  - PC=0xFFFF_FFFC with no redirect: next PC=0x0.
- Priority and jump forms:
  - PC=0x1000_0000, `jump`=1, `PCSrc`=1, jump_addr=26'h10: next PC=0x1000_0040 (jump wins).
  - Add `jump_reg`=1 with rs_data=0x2000: next PC=0x2000 (JR wins).
- Misaligned JR: rs_data=0x2002, `jump_reg`=1. PC=0x80 and `misalign_err`=1, still 1 after 5 further cycles, and the counter advanced by 1 for the trap.
- Stall and halt:
  - `stall`=1 with `PCSrc`=1 for 2 cycles: PC and count unchanged.
  - `halt`=1 with `stall`=1: `halted`=1 next edge, and PC/count frozen for 10 cycles despite `jump`=1.
  - Only `rst` clears `halted`.
- Counter wrap: preload via 2^32 advances, or force in simulation to 32'hFFFF_FFFF. One advance gives `instr_count`=0.
